tree_index_walker: RTL
======================

# tree_index_walker

Run-time sequencer that walks the same two-level iteration space our elaborated generate trees unroll at compile time. The outer level k runs over 0..NumLevels-1 and the inner offset l over 0..2**k-1. Each point is emitted as a beat carrying (level k, offset l, heap index 2**k+l) over a valid/ready stream. Downstream logic uses it to visit binary-tree nodes in breadth-first order, one node per accepted beat, and receives a completion pulse at the end.

## Interface
Parameters:
- NumLevels, default 3: number of tree levels; legal range 1..16.
- LvlWidth, default (NumLevels > 1) ? $clog2(NumLevels) : 1: derived; width of level_o.
- IdxWidth, default NumLevels: derived; width of offset_o and index_o.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  begin a walk; honoured only in IDLE.
- flush_i  in  1  synchronous abort; returns to IDLE with no done pulse.
- busy_o  out  1  high whenever state != IDLE.
- valid_o  out  1  beat available.
- ready_i  in  1  consumer accepts beat.
- level_o  out  LvlWidth  current k.
- offset_o  out  IdxWidth  current l (zero-extended).
- index_o  out  IdxWidth  2**k + l.
- level_last_o  out  1  beat is last of its level (l == 2**k-1).
- last_o  out  1  beat is final beat of walk (k == NumLevels-1 and level_last_o).
- done_o  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: valid_o=0. On start_i=1, load k=0, l=0 and go to RUN.
- RUN: valid_o=1. A handshake is valid_o && ready_i. On handshake:
  - if l != 2**k-1: l <= l+1;
  - else if k != NumLevels-1: k <= k+1, l <= 0;
  - else go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
- start_i while RUN or DONE is ignored. No queuing.
- flush_i=1 in RUN or DONE: next state is IDLE, and k and l are cleared. Any handshake in that same cycle still counts as consumed, but no done_o pulse follows. flush_i has priority over the advance.
- flush_i and start_i together in IDLE: flush wins and the block stays in IDLE.
- index_o is computed as (1 << k) | l. It is never zero while valid. Beats per walk = 2**NumLevels - 1. Maximum index = 2**NumLevels - 1, which fits IdxWidth with no overflow.
- Stream rule: while valid_o && !ready_i, the values of level_o, offset_o, index_o, level_last_o and last_o hold stable. valid_o never drops without a handshake, except on flush_i or reset.
- When valid_o=0, the data outputs are driven to 0.

## Timing
- Reset values: state IDLE, k=0, l=0; busy_o=0, valid_o=0, done_o=0; level_o, offset_o, index_o, level_last_o and last_o all 0.
- rst_i asserted mid-walk: all outputs take their reset values immediately (asynchronously). A walk does not resume after reset release.
- Latency: start_i sampled high at edge N gives valid_o high from cycle N+1.
- Throughput: one beat per cycle while ready_i=1.
- done_o is high in the cycle after the edge that accepts the last_o beat.
- busy_o spans from the cycle after the accepted start through the done_o cycle inclusive.
- The earliest restart is start_i in the first IDLE cycle after done_o.
- With ready_i held at 1, a walk occupies 2**NumLevels - 1 RUN cycles plus 1 DONE cycle.

## Test plan
- Full walk: NumLevels=3, ready_i=1, start_i pulsed at cycle 0.
  - index_o = 1,2,3,4,5,6,7 in cycles 1-7.
  - level_o = 0,1,1,2,2,2,2.
  - level_last_o high on indices 1, 3 and 7; last_o high only on 7.
  - done_o high in cycle 8 only; busy_o high in cycles 1-8.
- Backpressure: NumLevels=3, ready_i low in cycles 2-4.
  - index 2 is held stable for cycles 2-4 and accepted in cycle 5.
  - All 7 beats arrive, in order, exactly once; done_o one cycle after beat 7 is accepted.
- Ignored start: start_i pulsed at cycles 3 and 8 during a walk.
  - Sequence and done timing are identical to the full-walk scenario; no second walk starts.
  - A start in cycle 9 (IDLE) begins a new walk with index 1 in cycle 10.
- Flush: flush_i in cycle 4 (index 4 showing, ready_i=1).
  - Cycle 5: IDLE, valid_o=0, done_o never asserts.
  - A subsequent start begins again from index 1.
- Async reset mid-walk: rst_i rises between edges in cycle 5.
  - valid_o, busy_o and index_o go to 0 before the next edge.
  - After release, the block stays idle until a new start_i.
- Degenerate: NumLevels=1.
  - A single beat: index_o=1, level_o=0, offset_o=0, level_last_o=1, last_o=1.
  - done_o in the next cycle.

Source files
------------

// File: rtl/tree_index_walker.sv
// Breadth-first binary-tree walker: emits (level k, offset l, heap index 2**k+l) beats.
// Latency: start sampled at edge N gives first beat in cycle N+1; one beat per cycle.
// Backpressure: valid/ready stream; the beat and its fields hold stable while ready_i is low.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i, flush_i  begin a walk (IDLE only) / synchronous abort back to IDLE
//   busy_o, done_o    walk in progress / one-cycle completion pulse
//   valid_o, ready_i  beat handshake
//   level_o, offset_o, index_o, level_last_o, last_o   beat payload (zero when not valid)
module tree_index_walker #(
    parameter int NumLevels = 3,
    parameter int LvlWidth  = (NumLevels > 1) ? $clog2(NumLevels) : 1,
    parameter int IdxWidth  = NumLevels
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                flush_i,
    output logic                busy_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [LvlWidth-1:0] level_o,
    output logic [IdxWidth-1:0] offset_o,
    output logic [IdxWidth-1:0] index_o,
    output logic                level_last_o,
    output logic                last_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [LvlWidth-1:0] KLast = LvlWidth'(NumLevels - 1);

    state_e              state_q, state_d;
    logic [LvlWidth-1:0] k_q, k_d;
    logic [IdxWidth-1:0] l_q, l_d;

    // 2**k always fits IdxWidth because k never exceeds NumLevels-1.
    logic [IdxWidth-1:0] lvl_base;
    logic [IdxWidth-1:0] lvl_end;
    logic                is_lvl_last;
    logic                is_top_lvl;
    logic                run;

    assign lvl_base    = IdxWidth'(1) << k_q;
    assign lvl_end     = lvl_base - IdxWidth'(1);
    assign is_lvl_last = (l_q == lvl_end);
    assign is_top_lvl  = (k_q == KLast);
    assign run         = (state_q == RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l_q     <= l_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        l_d     = l_q;
        case (state_q)
            IDLE: begin
                // Flush beats a simultaneous start.
                if (!flush_i && start_i) begin
                    state_d = RUN;
                    k_d     = '0;
                    l_d     = '0;
                end
            end
            RUN: begin
                // Flush overrides the advance; a beat handshaken this cycle is
                // still considered consumed by the downstream side.
                if (flush_i) begin
                    state_d = IDLE;
                    k_d     = '0;
                    l_d     = '0;
                end else if (ready_i) begin
                    if (!is_lvl_last) begin
                        l_d = l_q + IdxWidth'(1);
                    end else if (!is_top_lvl) begin
                        k_d = k_q + LvlWidth'(1);
                        l_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Return to IDLE unconditionally; flush here only suppresses nothing
                // further since the pulse is this very cycle.
                state_d = IDLE;
                k_d     = '0;
                l_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                l_d     = '0;
            end
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign valid_o      = run;
    assign done_o       = (state_q == DONE);
    assign level_o      = run ? k_q : '0;
    assign offset_o     = run ? l_q : '0;
    assign index_o      = run ? (lvl_base | l_q) : '0;
    assign level_last_o = run & is_lvl_last;
    assign last_o       = run & is_lvl_last & is_top_lvl;

endmodule
